// File: rtl/cache_tag_check.sv
// cache_tag_check
// ---------------------------------------------------------------------------
// Tag lookup / tag fill engine for a WAYS-way, SETS-set cache.
// It holds a valid bit and a tag for every set/way. A lookup is answered one
// cycle after it is accepted, with a registered hit flag and hit way. A fill
// picks a victim way in this order: the way that already holds the tag, then
// the lowest invalid way, then the per-set round-robin pointer. A flush walks
// every set, one set per cycle, and clears its valid bits.
//
// Optional build macro:
//   TAG_PARITY_EN - store an even-parity bit with every tag. A lookup that
//                   matches a valid way whose parity is bad is reported as a
//                   miss. That way is invalidated and the sticky err is set.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   lkp_valid/index/tag   lookup request; lkp_ready = accept (idle, not busy)
//   rsp_valid/hit/way     registered lookup result, one cycle later
//   fill_valid/index/tag  tag install request (accepted when lkp_ready)
//   fill_done/fill_way    registered pulse / way written by the last fill
//   flush          start a flush of every set (sampled in IDLE only)
//   busy           flush in progress
//   err            sticky parity error (constant 0 without TAG_PARITY_EN)
// ---------------------------------------------------------------------------
module cache_tag_check #(
    parameter int  WAYS  = 4,
    parameter int  SETS  = 16,
    parameter int  TAG_W = 20,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lkp_valid,
    input  logic [IDX_W-1:0] lkp_index,
    input  logic [TAG_W-1:0] lkp_tag,
    output logic             lkp_ready,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAY_W-1:0] rsp_way,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [TAG_W-1:0] fill_tag,
    output logic             fill_done,
    output logic [WAY_W-1:0] fill_way,
    input  logic             flush,
    output logic             busy,
    output logic             err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             fcnt_q;

    logic [SETS-1:0][WAYS-1:0]    vld_q;
    logic [SETS-1:0][WAY_W-1:0]   ptr_q;
    logic [TAG_W-1:0]             tag_mem [SETS][WAYS];
`ifdef TAG_PARITY_EN
    logic                         par_mem [SETS][WAYS];
`endif

    logic                         lkp_acc, fill_acc;
    logic [WAYS-1:0]              lkp_tmatch, lkp_perr, lkp_hitv;
    logic [WAYS-1:0]              fill_match, fill_inv;
    logic                         hit_any;
    logic [WAY_W-1:0]             hit_way;
    logic [WAY_W-1:0]             victim;
    logic                         ptr_adv;
    logic [WAY_W-1:0]             ptr_cur, ptr_next;

    // Requests are accepted only in IDLE. A flush in the same cycle drops them.
    assign lkp_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_FLUSH);
    assign lkp_acc   = lkp_valid  & lkp_ready & ~flush;
    assign fill_acc  = fill_valid & lkp_ready & ~flush;

    // Per-way compare against the contents before this edge. A lookup and a
    // fill in the same cycle therefore see the pre-fill state.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign lkp_tmatch[w] = vld_q[lkp_index][w] && (tag_mem[lkp_index][w] == lkp_tag);
`ifdef TAG_PARITY_EN
        assign lkp_perr[w]   = lkp_tmatch[w] && (par_mem[lkp_index][w] != ^tag_mem[lkp_index][w]);
`else
        assign lkp_perr[w]   = 1'b0;
`endif
        assign lkp_hitv[w]   = lkp_tmatch[w] & ~lkp_perr[w];
        assign fill_match[w] = vld_q[fill_index][w] && (tag_mem[fill_index][w] == fill_tag);
        assign fill_inv[w]   = ~vld_q[fill_index][w];
    end

    // Lowest-index hit wins. The downward loop leaves the smallest index set.
    always_comb begin
        hit_any = |lkp_hitv;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lkp_hitv[w]) hit_way = WAY_W'(w);
        end
    end

    // Victim selection: existing copy, then first invalid way, then round robin.
    assign ptr_cur  = ptr_q[fill_index];
    assign ptr_next = (ptr_cur == WAY_W'(WAYS - 1)) ? '0 : ptr_cur + WAY_W'(1);

    always_comb begin
        victim  = ptr_cur;
        ptr_adv = 1'b0;
        if (|fill_match) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (fill_match[w]) victim = WAY_W'(w);
            end
        end else if (|fill_inv) begin
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (fill_inv[w]) victim = WAY_W'(w);
            end
        end else begin
            ptr_adv = 1'b1;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (flush) state_d = S_FLUSH;
            S_FLUSH: if (fcnt_q == IDX_W'(SETS - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The set counter runs only while flushing. It wraps to 0 on the last
    // set because SETS is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= (state_q == S_FLUSH) ? fcnt_q + IDX_W'(1) : '0;
        end
    end

    // Valid bits and replacement pointers. Pointers survive a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ptr_q <= '0;
        end else begin
            if (state_q == S_FLUSH) vld_q[fcnt_q] <= '0;
`ifdef TAG_PARITY_EN
            // A corrupt entry is dropped so the next lookup cleanly misses.
            if (lkp_acc) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (lkp_perr[w]) vld_q[lkp_index][w] <= 1'b0;
                end
            end
`endif
            if (fill_acc) begin
                vld_q[fill_index][victim] <= 1'b1;
                if (ptr_adv) ptr_q[fill_index] <= ptr_next;
            end
        end
    end

    // Tag storage has no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            tag_mem[fill_index][victim] <= fill_tag;
`ifdef TAG_PARITY_EN
            par_mem[fill_index][victim] <= ^fill_tag;
`endif
        end
    end

    // Registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_way   <= '0;
            fill_done <= 1'b0;
            fill_way  <= '0;
        end else begin
            rsp_valid <= lkp_acc;
            rsp_hit   <= lkp_acc & hit_any;
            rsp_way   <= lkp_acc ? hit_way : '0;
            fill_done <= fill_acc;
            if (fill_acc) fill_way <= victim;
        end
    end

`ifdef TAG_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)                        err <= 1'b0;
        else if (lkp_acc && |lkp_perr)  err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_tag_check.sv
module tb_cache_tag_check;
    localparam int WAYS  = 4;
    localparam int SETS  = 16;
    localparam int TAG_W = 20;
    localparam int WAY_W = 2;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             lkp_valid;
    logic [IDX_W-1:0] lkp_index;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_ready;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAY_W-1:0] rsp_way;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_done;
    logic [WAY_W-1:0] fill_way;
    logic             flush;
    logic             busy;
    logic             err;

    cache_tag_check #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
        .lkp_ready(lkp_ready),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_done(fill_done), .fill_way(fill_way),
        .flush(flush), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int checks      = 0;
    int miscompares = 0;

    // Reference cache contents: what the cache should hold, by the rules.
    bit m_vld [SETS][WAYS];
    int m_tag [SETS][WAYS];
    int m_ptr [SETS];
    bit m_err;

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_vld[s][w] = 0;
                m_tag[s][w] = 0;
            end
        end
        m_err = 0;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_vld[s][w] = 0;
    endfunction

    function automatic void m_lookup(input int idx, input int tag, output bit h, output int way);
        h = 0;
        way = 0;
        for (int w = 0; w < WAYS; w++)
            if (!h && m_vld[idx][w] && m_tag[idx][w] == tag) begin
                h = 1;
                way = w;
            end
    endfunction

    function automatic int m_fill(input int idx, input int tag);
        int v = -1;
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && m_vld[idx][w] && m_tag[idx][w] == tag) v = w;
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && !m_vld[idx][w]) v = w;
        if (v < 0) begin
            v = m_ptr[idx];
            m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
        end
        m_vld[idx][v] = 1;
        m_tag[idx][v] = tag;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle with an optional lookup and an optional fill. The expected
    // result comes from the model before the fill is applied.
    task automatic do_op(input bit lv, input int li, input int lt,
                         input bit fv, input int fi, input int ft, output int fw);
        bit eh;
        int ew;
        eh = 0;
        ew = 0;
        fw = 0;
        if (lv) m_lookup(li, lt, eh, ew);
        if (fv) fw = m_fill(fi, ft);
        lkp_valid  = lv;
        lkp_index  = IDX_W'(li);
        lkp_tag    = TAG_W'(lt);
        fill_valid = fv;
        fill_index = IDX_W'(fi);
        fill_tag   = TAG_W'(ft);
        cyc();
        lkp_valid  = 0;
        fill_valid = 0;
        vectors++;
        chk("rsp_valid", rsp_valid, lv);
        if (lv) begin
            chk("rsp_hit", rsp_hit, eh);
            chk("rsp_way", rsp_way, ew);
        end
        chk("fill_done", fill_done, fv);
        if (fv) chk("fill_way", fill_way, fw);
        chk("err", err, m_err);
        chk("lkp_ready", lkp_ready, 1);
    endtask

    // Flush, with a lookup and a fill offered in the same cycle. Both must be
    // dropped. Lookups offered during the flush must also be ignored.
    task automatic do_flush();
        flush      = 1;
        lkp_valid  = 1;
        lkp_index  = 3;
        lkp_tag    = 'h77;
        fill_valid = 1;
        fill_index = 3;
        fill_tag   = 'h77;
        cyc();
        fill_valid = 0;
        m_flush();
        for (int k = 0; k < SETS; k++) begin
            vectors++;
            chk("flush_busy", busy, 1);
            chk("flush_ready", lkp_ready, 0);
            chk("flush_rsp", rsp_valid, 0);
            chk("flush_fdone", fill_done, 0);
            flush     = (k < SETS - 2);
            lkp_valid = 1;
            lkp_index = IDX_W'($urandom_range(0, SETS - 1));
            cyc();
        end
        flush     = 0;
        lkp_valid = 0;
        chk("flush_end_busy", busy, 0);
        chk("flush_end_ready", lkp_ready, 1);
        chk("flush_end_rsp", rsp_valid, 0);
    endtask

    int fw;
    int exp5 [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1;
        lkp_valid = 0; lkp_index = 0; lkp_tag = 0;
        fill_valid = 0; fill_index = 0; fill_tag = 0;
        flush = 0;
        m_reset();
        cyc();
        cyc();
        rst = 0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_way", rsp_way, 0);
        chk("rst_fill_done", fill_done, 0);
        chk("rst_fill_way", fill_way, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", lkp_ready, 1);
        chk("rst_err", err, 0);

        // Miss on an empty cache, then fill and hit.
        do_op(1, 3, 'h00ABC, 0, 0, 0, fw);
        do_op(0, 0, 0, 1, 3, 'h00ABC, fw);
        chk("abc_fill_way", fill_way, 0);
        do_op(1, 3, 'h00ABC, 0, 0, 0, fw);
        chk("abc_hit", rsp_hit, 1);

        // Five fills into set 5: the fifth replaces way 0.
        for (int i = 0; i < 5; i++) begin
            do_op(0, 0, 0, 1, 5, i + 1, fw);
            chk("set5_way", fill_way, exp5[i]);
        end
        do_op(1, 5, 1, 0, 0, 0, fw);
        chk("set5_tag1_miss", rsp_hit, 0);
        do_op(1, 5, 2, 0, 0, 0, fw);
        chk("set5_tag2_way", rsp_way, 1);
        // Refilling a present tag rewrites its way; next eviction uses ptr=1.
        do_op(0, 0, 0, 1, 5, 3, fw);
        chk("set5_refill", fill_way, 2);
        do_op(0, 0, 0, 1, 5, 6, fw);
        chk("set5_rr", fill_way, 1);

        // Same-cycle fill and lookup of one set see the old contents.
        do_op(1, 7, 9, 1, 7, 9, fw);
        chk("same_cyc_miss", rsp_hit, 0);
        do_op(1, 7, 9, 0, 0, 0, fw);
        chk("next_cyc_hit", rsp_hit, 1);
        // Back-to-back lookups
        do_op(1, 7, 9, 0, 0, 0, fw);
        do_op(1, 3, 'h00ABC, 0, 0, 0, fw);

        // Flush, then everything misses.
        do_op(0, 0, 0, 1, 0, 'h11, fw);
        do_op(0, 0, 0, 1, 15, 'h22, fw);
        do_op(0, 0, 0, 1, 8, 'h33, fw);
        do_flush();
        do_op(1, 0, 'h11, 0, 0, 0, fw);
        do_op(1, 15, 'h22, 0, 0, 0, fw);
        do_op(1, 8, 'h33, 0, 0, 0, fw);
        do_op(1, 7, 9, 0, 0, 0, fw);
        chk("post_flush_miss", rsp_hit, 0);

        // Reset in the second flush cycle aborts the flush.
        do_op(0, 0, 0, 1, 2, 'h44, fw);
        flush = 1;
        cyc();
        flush = 0;
        chk("flush1_busy", busy, 1);
        cyc();
        chk("flush2_busy", busy, 1);
        rst = 1;
        cyc();
        rst = 0;
        m_reset();
        chk("abort_busy", busy, 0);
        chk("abort_ready", lkp_ready, 1);
        chk("abort_fdone", fill_done, 0);

        // Reset with a fill in the same cycle drops the fill.
        fill_valid = 1; fill_index = 4; fill_tag = 'h55; rst = 1;
        cyc();
        rst = 0; fill_valid = 0;
        chk("rst_fill_dropped", fill_done, 0);
        do_op(1, 4, 'h55, 0, 0, 0, fw);
        do_op(1, 2, 'h44, 0, 0, 0, fw);

        // Random traffic over a few sets and a small tag pool.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_flush();
            end else begin
                do_op(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 8),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 8), fw);
            end
        end

`ifdef TAG_PARITY_EN
        rst = 1;
        cyc();
        rst = 0;
        m_reset();
        do_op(0, 0, 0, 1, 2, 'h10, fw);
        dut.tag_mem[2][0] = dut.tag_mem[2][0] ^ TAG_W'(1);
        lkp_valid = 1; lkp_index = 2; lkp_tag = 'h11;
        cyc();
        lkp_valid = 0;
        vectors++;
        chk("par_rsp_valid", rsp_valid, 1);
        chk("par_hit", rsp_hit, 0);
        chk("par_err", err, 1);
        m_err = 1;
        do_op(1, 2, 'h11, 0, 0, 0, fw);
        do_op(1, 2, 'h10, 0, 0, 0, fw);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
